// File: rtl/imm_pack_if.sv
// Request/result handshake bundle for imm_pack: encode request in, packed immediate out.
interface imm_pack_if #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned C_WIDTH = 2,
    parameter int unsigned I_WIDTH = 31
);
    logic               inValid;
    logic               inReady;
    logic [C_WIDTH:0]   immSrc;
    logic [I_WIDTH:0]   immVal;
    logic               outValid;
    logic               outReady;
    logic [WIDTH:0]     imm;
    logic               immErr;

    modport master (
        output inValid, immSrc, immVal, outReady,
        input  inReady, outValid, imm, immErr
    );

    modport slave (
        input  inValid, immSrc, immVal, outReady,
        output inReady, outValid, imm, immErr
    );
endinterface

// File: rtl/imm_pack.sv
// Packs a 32-bit immediate into instruction bits [31:7] per format, behind a 2-entry result FIFO.
// Define IMM_PACK_RANGE_CHECK_EN to flag immediates that the chosen format cannot represent.
module imm_pack #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned C_WIDTH = 2,
    parameter int unsigned I_WIDTH = 31
) (
    input logic        clk,
    input logic        reset_n,
    imm_pack_if.slave  bus
);
    localparam logic [C_WIDTH:0] FmtI = 'd0;
    localparam logic [C_WIDTH:0] FmtS = 'd1;
    localparam logic [C_WIDTH:0] FmtB = 'd2;
    localparam logic [C_WIDTH:0] FmtU = 'd3;
    localparam logic [C_WIDTH:0] FmtJ = 'd4;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e             state_q, state_d;
    logic [WIDTH+1:0]   head_q, head_d;   // {immErr, imm}
    logic [WIDTH+1:0]   tail_q, tail_d;

    logic [C_WIDTH:0]   src;
    logic [I_WIDTH:0]   v;
    logic [WIDTH:0]     enc;
    logic               err;
    logic               push, pop;

    assign src = bus.immSrc;
    assign v   = bus.immVal;

    always_comb begin
        enc = '0;
        err = 1'b0;
        case (src)
            FmtI: begin
                enc[24:13] = v[11:0];
`ifdef IMM_PACK_RANGE_CHECK_EN
                err = !((&v[31:11]) || !(|v[31:11]));
`endif
            end
            FmtS: begin
                enc[24:18] = v[11:5];
                enc[4:0]   = v[4:0];
`ifdef IMM_PACK_RANGE_CHECK_EN
                err = !((&v[31:11]) || !(|v[31:11]));
`endif
            end
            FmtB: begin
                enc[24]    = v[12];
                enc[23:18] = v[10:5];
                enc[4:1]   = v[4:1];
                enc[0]     = v[11];
`ifdef IMM_PACK_RANGE_CHECK_EN
                err = !((&v[31:12]) || !(|v[31:12])) || v[0];
`endif
            end
            FmtU: begin
                enc[24:5] = v[31:12];
`ifdef IMM_PACK_RANGE_CHECK_EN
                err = |v[11:0];
`endif
            end
            FmtJ: begin
                enc[24]    = v[20];
                enc[23:14] = v[10:1];
                enc[13]    = v[11];
                enc[12:5]  = v[19:12];
`ifdef IMM_PACK_RANGE_CHECK_EN
                err = !((&v[31:20]) || !(|v[31:20])) || v[0];
`endif
            end
            default: begin
                enc = '0;
                err = 1'b1;
            end
        endcase
    end

    assign bus.inReady  = (state_q != StFull);
    assign bus.outValid = (state_q != StEmpty);
    assign bus.imm      = head_q[WIDTH:0];
    assign bus.immErr   = head_q[WIDTH+1];

    assign push = bus.inValid && bus.inReady;
    assign pop  = bus.outValid && bus.outReady;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            StEmpty: begin
                if (push) begin
                    head_d  = {err, enc};
                    state_d = StOne;
                end
            end
            StOne: begin
                // Simultaneous push/pop replaces the head so the new entry shows next cycle.
                if (push && pop) begin
                    head_d = {err, enc};
                end else if (push) begin
                    tail_d  = {err, enc};
                    state_d = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end
endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: directed cases plus randomized traffic against a queue model.
module tb_imm_pack;
    logic clk = 1'b0;
    logic reset_n;
    int   ntests = 0;
    int   nfail  = 0;
    logic [25:0] q[$];   // expected {immErr, imm}, head first

    always #5 clk = ~clk;

    imm_pack_if bus ();

    imm_pack dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference: arithmetic field extraction, range limits as signed intervals.
    function automatic logic [25:0] model(input logic [2:0] fsrc, input logic [31:0] val);
        int unsigned u;
        int          s;
        int unsigned r;
        logic        e;
        u = val;
        s = signed'(val);
        r = 0;
        e = 1'b0;
        case (fsrc)
            3'd0: begin
                r = (u % 4096) << 13;
                e = (s < -2048) || (s > 2047);
            end
            3'd1: begin
                r = (((u / 32) % 128) << 18) + (u % 32);
                e = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                r = (((u / 4096) % 2) << 24) + (((u / 32) % 64) << 18)
                  + (((u / 2) % 16) << 1) + ((u / 2048) % 2);
                e = (s < -4096) || (s > 4095) || (u % 2 == 1);
            end
            3'd3: begin
                r = (u / 4096) << 5;
                e = (u % 4096) != 0;
            end
            3'd4: begin
                r = (((u / 1048576) % 2) << 24) + (((u / 2) % 1024) << 14)
                  + (((u / 2048) % 2) << 13) + (((u / 4096) % 256) << 5);
                e = (s < -1048576) || (s > 1048575) || (u % 2 == 1);
            end
            default: begin
                r = 0;
                e = 1'b1;
            end
        endcase
`ifndef IMM_PACK_RANGE_CHECK_EN
        if (fsrc < 3'd5) e = 1'b0;
`endif
        return {e, r[24:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [2:0] fsrc, input logic [31:0] val,
                         input logic ordy);
        bus.inValid  = iv;
        bus.immSrc   = fsrc;
        bus.immVal   = val;
        bus.outReady = ordy;
    endtask

    // One clock: check outputs against the model, then advance model on the edge.
    task automatic step();
        logic        push, pop;
        logic [25:0] e;
        @(negedge clk);
        chk("inReady", {31'd0, bus.inReady}, {31'd0, q.size() < 2});
        chk("outValid", {31'd0, bus.outValid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            e = q[0];
            chk("imm", {7'd0, bus.imm}, {7'd0, e[24:0]});
            chk("immErr", {31'd0, bus.immErr}, {31'd0, e[25]});
        end
        push = bus.inValid && (q.size() < 2);
        pop  = (q.size() > 0) && bus.outReady;
        e    = model(bus.immSrc, bus.immVal);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [24:0] eimm, input logic eerr);
        chk({tag, ".valid"}, {31'd0, bus.outValid}, 32'd1);
        chk({tag, ".imm"}, {7'd0, bus.imm}, {7'd0, eimm});
        chk({tag, ".err"}, {31'd0, bus.immErr}, {31'd0, eerr});
    endtask

    initial begin
        logic [31:0] val;
        logic [2:0]  fsrc;
        reset_n = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 1'b0);
        #1;
        chk("rst.outValid", {31'd0, bus.outValid}, 32'd0);
        chk("rst.inReady", {31'd0, bus.inReady}, 32'd1);
        chk("rst.imm", {7'd0, bus.imm}, 32'd0);
        chk("rst.immErr", {31'd0, bus.immErr}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // Known encodings, each one cycle after acceptance
        drive(1'b1, 3'd0, 32'hFFFF_F800, 1'b1); step();
        expect_head("i_neg", 25'h100_0000, 1'b0);
        drive(1'b1, 3'd2, 32'h0000_0FFE, 1'b1); step();
        expect_head("b_fe", 25'h0FC_001F, 1'b0);
        drive(1'b1, 3'd3, 32'h1234_5000, 1'b1); step();
        expect_head("u_val", 25'h024_68A0, 1'b0);
        drive(1'b1, 3'd0, 32'h0000_0800, 1'b1); step();
`ifdef IMM_PACK_RANGE_CHECK_EN
        chk("i_ovf.err", {31'd0, bus.immErr}, 32'd1);
`else
        expect_head("i_ovf", 25'h100_0000, 1'b0);
`endif
        drive(1'b1, 3'd7, 32'h0000_0004, 1'b1); step();
        expect_head("src7", 25'h0, 1'b1);
        drive(1'b0, 3'd0, 32'd0, 1'b1); step(); step();

        // Backpressure: two accepts fill the FIFO, third waits for a pop
        drive(1'b1, 3'd0, 32'd1, 1'b0); step();
        drive(1'b1, 3'd0, 32'd2, 1'b0); step();
        chk("full.inReady", {31'd0, bus.inReady}, 32'd0);
        drive(1'b1, 3'd0, 32'd3, 1'b0); step();
        chk("full.hold", {7'd0, bus.imm}, 32'd1 << 13);
        drive(1'b1, 3'd0, 32'd3, 1'b1); step();
        expect_head("bp.second", 25'd2 << 13, 1'b0);
        step();
        expect_head("bp.third", 25'd3 << 13, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 1'b1); step(); step();

        // Asynchronous reset while full
        drive(1'b1, 3'd1, 32'd5, 1'b0); step(); step();
        chk("pre_rst.inReady", {31'd0, bus.inReady}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.outValid", {31'd0, bus.outValid}, 32'd0);
        chk("arst.inReady", {31'd0, bus.inReady}, 32'd1);
        chk("arst.imm", {7'd0, bus.imm}, 32'd0);
        q.delete();
        drive(1'b0, 3'd0, 32'd0, 1'b1);
        @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (3) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            fsrc = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: val = $urandom;
                1: val = 32'(signed'($urandom_range(0, 8191)) - 4096);
                2: val = $urandom & 32'hFFFF_F000;
                default: val = 32'(signed'($urandom_range(0, 4194303)) - 2097152) & ~32'd1;
            endcase
            drive(($urandom % 4) != 0, fsrc, val, ($urandom % 3) != 0);
            step();
        end
        drive(1'b0, 3'd0, 32'd0, 1'b1);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
